// File: rtl/cve2_ex_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cve2_ex_sequencer
// Brief   : ID-side controller for the execute stage. It issues one decoded
//           instruction at a time, drives the EX enables/selects, owns the two
//           34-bit intermediate value registers and holds each result in a
//           writeback slot until the register file accepts it.
// Revision: 1.0 - initial release
// ============================================================================
module cve2_ex_sequencer #(
    parameter bit          MultDivEn     = 1'b1,
    parameter int unsigned MaxExecCycles = 40
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [1:0]       op_class_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic             alu_instr_first_cycle_o,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output logic             multdiv_ready_id_o,
    input  logic             ex_valid_i,
    input  logic [31:0]      result_ex_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic [1:0][33:0] imd_val_d_i,
    output logic [1:0][33:0] imd_val_q_o,
    output logic             wb_valid_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    input  logic             wb_ready_i,
    output logic             err_o,
    output logic             busy_o
);

    localparam logic [1:0] c_CLS_MULT  = 2'd1;
    localparam logic [1:0] c_CLS_DIV   = 2'd2;
    localparam logic [7:0] c_CNT_LAST  = 8'(MaxExecCycles - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WB_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  class_q, class_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;
    logic [33:0] imd_q [2];

    logic        w_accept;
    logic        w_illegal;
    logic        w_exec;

    // A new instruction can enter from IDLE or on the writeback handshake.
    assign instr_ready_o = ~flush_i & ((state_q == IDLE) |
                                       ((state_q == WB_HOLD) & wb_ready_i));
    assign w_accept  = instr_valid_i & instr_ready_o;
    assign w_illegal = w_accept & (MultDivEn == 1'b0) &
                       ((op_class_i == c_CLS_MULT) | (op_class_i == c_CLS_DIV));
    assign w_exec    = (state_q == EXEC);

    // Next-state, slot capture and error pulse; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (ex_valid_i) begin
                        cnt_d = 8'd0;
                        if (rd_q != 5'd0) begin
                            wb_rd_d   = rd_q;
                            wb_data_d = result_ex_i;
                            state_d   = WB_HOLD;
                        end else begin
                            state_d   = IDLE;
                        end
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                WB_HOLD: begin
                    if (wb_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // Acceptance is only possible from IDLE or the WB handshake.
            if (w_accept) begin
                if (w_illegal) begin
                    err_d = 1'b1;
                end else begin
                    state_d = EXEC;
                    class_d = op_class_i;
                    rd_d    = rd_addr_i;
                    cnt_d   = 8'd0;
                end
            end
        end
    end

    // Control and writeback slot registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            class_q   <= 2'd0;
            rd_q      <= 5'd0;
            cnt_q     <= 8'd0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    // Intermediate value registers, written by EX only while executing.
    for (genvar k = 0; k < 2; k++) begin : g_imd
        // Load on write enable in EXEC; a flush blocks the same-cycle write.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                imd_q[k] <= 34'd0;
            end else if (w_exec && !flush_i && imd_val_we_i[k]) begin
                imd_q[k] <= imd_val_d_i[k];
            end
        end
        assign imd_val_q_o[k] = imd_q[k];
    end

    assign alu_instr_first_cycle_o = w_exec & (cnt_q == 8'd0);
    assign mult_en_o               = w_exec & (class_q == c_CLS_MULT);
    assign mult_sel_o              = w_exec & (class_q == c_CLS_MULT);
    assign div_en_o                = w_exec & (class_q == c_CLS_DIV);
    assign div_sel_o               = w_exec & (class_q == c_CLS_DIV);
    assign multdiv_ready_id_o      = w_exec;
    assign wb_valid_o              = (state_q == WB_HOLD);
    assign wb_rd_o                 = wb_rd_q;
    assign wb_data_o               = wb_data_q;
    assign err_o                   = err_q;
    assign busy_o                  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cve2_ex_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cve2_ex_sequencer
// Brief   : Self-checking bench: vector table of single instructions, a
//           writeback scoreboard, and hand sequences for stall, timeout,
//           illegal class, flush and mid-operation reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cve2_ex_sequencer;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             instr_valid_i, flush_i, ex_valid_i, wb_ready_i;
    logic [1:0]       op_class_i;
    logic [4:0]       rd_addr_i;
    logic [31:0]      result_ex_i;
    logic [1:0]       imd_val_we_i;
    logic [1:0][33:0] imd_val_d_i;
    logic             instr_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o;
    logic             mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o, err_o, busy_o;
    logic [1:0][33:0] imd_val_q_o;
    logic [4:0]       wb_rd_o;
    logic [31:0]      wb_data_o;

    // Second instance without the M extension.
    logic             d0_instr_valid;
    logic [1:0]       d0_op_class;
    logic             d0_ready, d0_first, d0_mult_en, d0_div_en, d0_mult_sel, d0_div_sel;
    logic             d0_md_ready, d0_wb_valid, d0_err, d0_busy;
    logic [1:0][33:0] d0_imd_q;
    logic [4:0]       d0_wb_rd;
    logic [31:0]      d0_wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [31:0] data;
        int          lat;
        logic        exp_mult;
        logic        exp_div;
        logic        exp_wb;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[6];

    always #5 clk_i = ~clk_i;

    cve2_ex_sequencer #(.MultDivEn(1'b1), .MaxExecCycles(40)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .op_class_i(op_class_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .alu_instr_first_cycle_o(alu_instr_first_cycle_o),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o),
        .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
        .multdiv_ready_id_o(multdiv_ready_id_o),
        .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
        .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i), .imd_val_q_o(imd_val_q_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .wb_ready_i(wb_ready_i), .err_o(err_o), .busy_o(busy_o)
    );

    cve2_ex_sequencer #(.MultDivEn(1'b0), .MaxExecCycles(40)) dut_nomd (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(d0_instr_valid), .instr_ready_o(d0_ready),
        .op_class_i(d0_op_class), .rd_addr_i(5'd6), .flush_i(1'b0),
        .alu_instr_first_cycle_o(d0_first),
        .mult_en_o(d0_mult_en), .div_en_o(d0_div_en),
        .mult_sel_o(d0_mult_sel), .div_sel_o(d0_div_sel),
        .multdiv_ready_id_o(d0_md_ready),
        .ex_valid_i(1'b0), .result_ex_i(32'd0),
        .imd_val_we_i(2'b00), .imd_val_d_i('0), .imd_val_q_o(d0_imd_q),
        .wb_valid_o(d0_wb_valid), .wb_rd_o(d0_wb_rd), .wb_data_o(d0_wb_data),
        .wb_ready_i(1'b1), .err_o(d0_err), .busy_o(d0_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every completed writeback handshake must match the oldest
    // expected result; err_o and wb_valid_o must never coincide.
    always @(negedge clk_i) begin
        if (wb_valid_o || err_o)
            chk("err_wb_exclusive", 64'(wb_valid_o & err_o), 64'd0);
        if (wb_valid_o && wb_ready_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_wb: got rd=%0d data=0x%0h, expected none",
                         wb_rd_o, wb_data_o);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_wb_rd", 64'(wb_rd_o), 64'(e.rd));
                chk("sb_wb_data", 64'(wb_data_o), 64'(e.data));
            end
        end
    end

    // One instruction from the table: accept, lat EXEC cycles, writeback.
    task automatic run_vec(input vec_t v);
        instr_valid_i = 1'b1;
        op_class_i    = v.cls;
        rd_addr_i     = v.rd;
        #1 chk("vec_ready", 64'(instr_ready_o), 64'd1);
        tick();
        instr_valid_i = 1'b0;
        for (int c = 0; c < v.lat; c++) begin
            chk("vec_first_cycle", 64'(alu_instr_first_cycle_o), 64'(c == 0));
            chk("vec_mult_en", 64'({mult_en_o, mult_sel_o}), 64'({v.exp_mult, v.exp_mult}));
            chk("vec_div_en", 64'({div_en_o, div_sel_o}), 64'({v.exp_div, v.exp_div}));
            chk("vec_md_ready", 64'(multdiv_ready_id_o), 64'd1);
            if (c == v.lat - 1) begin
                ex_valid_i  = 1'b1;
                result_ex_i = v.data;
                if (v.exp_wb) sb_q.push_back('{rd: v.rd, data: v.data});
            end
            tick();
        end
        ex_valid_i = 1'b0;
        chk("vec_wb_valid", 64'(wb_valid_o), 64'(v.exp_wb));
        chk("vec_busy_after_ex", 64'(busy_o), 64'(v.exp_wb));
        chk("vec_enables_off", 64'({mult_en_o, div_en_o}), 64'd0);
        tick();
        chk("vec_idle", 64'({busy_o, wb_valid_o}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected $finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [33:0] x0, x1;
        int n;

        vecs[0] = '{cls: 2'd0, rd: 5'd5,  data: 32'h1234_5678, lat: 1, exp_mult: 1'b0, exp_div: 1'b0, exp_wb: 1'b1};
        vecs[1] = '{cls: 2'd0, rd: 5'd0,  data: 32'hDEAD_BEEF, lat: 1, exp_mult: 1'b0, exp_div: 1'b0, exp_wb: 1'b0};
        vecs[2] = '{cls: 2'd3, rd: 5'd31, data: 32'hA5A5_0F0F, lat: 3, exp_mult: 1'b0, exp_div: 1'b0, exp_wb: 1'b1};
        vecs[3] = '{cls: 2'd1, rd: 5'd12, data: 32'h0000_FFFF, lat: 5, exp_mult: 1'b1, exp_div: 1'b0, exp_wb: 1'b1};
        vecs[4] = '{cls: 2'd2, rd: 5'd1,  data: 32'h8000_0001, lat: 2, exp_mult: 1'b0, exp_div: 1'b1, exp_wb: 1'b1};
        vecs[5] = '{cls: 2'd1, rd: 5'd0,  data: 32'h0000_0001, lat: 2, exp_mult: 1'b1, exp_div: 1'b0, exp_wb: 1'b0};

        rst_i = 1'b1; instr_valid_i = 1'b0; op_class_i = 2'd0; rd_addr_i = 5'd0;
        flush_i = 1'b0; ex_valid_i = 1'b0; result_ex_i = 32'd0; wb_ready_i = 1'b1;
        imd_val_we_i = 2'b00; imd_val_d_i = '0;
        d0_instr_valid = 1'b0; d0_op_class = 2'd0;
        repeat (3) @(posedge clk_i);
        #1;
        // Reset values
        chk("rst_ready", 64'(instr_ready_o), 64'd1);
        chk("rst_ctrl", 64'({alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o,
                             div_sel_o, multdiv_ready_id_o, wb_valid_o, err_o, busy_o}), 64'd0);
        chk("rst_wb", 64'({wb_rd_o, wb_data_o}), 64'd0);
        chk("rst_imd0", 64'(imd_val_q_o[0]), 64'd0);
        chk("rst_imd1", 64'(imd_val_q_o[1]), 64'd0);
        rst_i = 1'b0;
        tick();

        // Table-driven single instructions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // DIV for 34 cycles with both imd registers written every cycle
        instr_valid_i = 1'b1; op_class_i = 2'd2; rd_addr_i = 5'd7;
        tick();
        instr_valid_i = 1'b0;
        for (int i = 0; i < 34; i++) begin
            chk("div_en", 64'({div_en_o, div_sel_o, mult_en_o}), 64'b110);
            if (i > 0) begin
                chk("div_imd0", 64'(imd_val_q_o[0]), 64'(34'((i - 1) * 3 + 1)));
                chk("div_imd1", 64'(imd_val_q_o[1]), 64'({2'b10, 32'(i - 1)}));
            end
            imd_val_we_i   = 2'b11;
            imd_val_d_i[0] = 34'(i * 3 + 1);
            imd_val_d_i[1] = {2'b10, 32'(i)};
            if (i == 33) begin
                ex_valid_i  = 1'b1;
                result_ex_i = 32'hC0DE_0034;
                sb_q.push_back('{rd: 5'd7, data: 32'hC0DE_0034});
            end
            tick();
        end
        ex_valid_i = 1'b0; imd_val_we_i = 2'b00;
        chk("div_done_wb", 64'(wb_valid_o), 64'd1);
        chk("div_done_en", 64'(div_en_o), 64'd0);
        chk("div_last_imd0", 64'(imd_val_q_o[0]), 64'(34'(33 * 3 + 1)));
        chk("div_last_imd1", 64'(imd_val_q_o[1]), 64'({2'b10, 32'd33}));
        // A write outside EXEC must be ignored.
        imd_val_we_i = 2'b11; imd_val_d_i = '0;
        tick();
        imd_val_we_i = 2'b00;
        chk("imd_write_outside_exec", 64'(imd_val_q_o[0]), 64'(34'(33 * 3 + 1)));

        // Back-to-back ALU ops with a 3-cycle writeback stall
        instr_valid_i = 1'b1; op_class_i = 2'd0; rd_addr_i = 5'd3;
        tick();
        instr_valid_i = 1'b0;
        ex_valid_i = 1'b1; result_ex_i = 32'h0BAD_F00D; wb_ready_i = 1'b0;
        sb_q.push_back('{rd: 5'd3, data: 32'h0BAD_F00D});
        tick();
        ex_valid_i = 1'b0;
        instr_valid_i = 1'b1; rd_addr_i = 5'd4;
        for (int s = 0; s < 3; s++) begin
            chk("stall_wb_valid", 64'(wb_valid_o), 64'd1);
            chk("stall_wb_stable", 64'({wb_rd_o, wb_data_o}), 64'({5'd3, 32'h0BAD_F00D}));
            #1 chk("stall_ready_low", 64'(instr_ready_o), 64'd0);
            tick();
        end
        wb_ready_i = 1'b1;
        #1 chk("handshake_ready", 64'(instr_ready_o), 64'd1);
        tick();
        instr_valid_i = 1'b0;
        chk("b2b_first_cycle", 64'({alu_instr_first_cycle_o, busy_o, wb_valid_o}), 64'b110);
        ex_valid_i = 1'b1; result_ex_i = 32'h600D_CAFE;
        sb_q.push_back('{rd: 5'd4, data: 32'h600D_CAFE});
        tick();
        ex_valid_i = 1'b0;
        chk("b2b_wb", 64'({wb_valid_o, wb_rd_o}), 64'({1'b1, 5'd4}));
        tick();
        chk("b2b_idle", 64'(busy_o), 64'd0);

        // Illegal MULT and DIV on the instance without M extension
        for (int c = 1; c <= 2; c++) begin
            d0_instr_valid = 1'b1; d0_op_class = 2'(c);
            #1 chk("illegal_ready", 64'(d0_ready), 64'd1);
            tick();
            d0_instr_valid = 1'b0;
            chk("illegal_err", 64'(d0_err), 64'd1);
            chk("illegal_no_issue", 64'({d0_busy, d0_mult_en, d0_div_en, d0_wb_valid}), 64'd0);
            tick();
            chk("illegal_err_pulse", 64'({d0_err, d0_busy}), 64'd0);
        end

        // Timeout: EXEC without ex_valid_i
        instr_valid_i = 1'b1; op_class_i = 2'd3; rd_addr_i = 5'd9;
        tick();
        instr_valid_i = 1'b0;
        n = 0;
        while (busy_o && n < 60) begin
            n++;
            tick();
        end
        chk("timeout_cycles", 64'(n), 64'd40);
        chk("timeout_err", 64'({err_o, busy_o, wb_valid_o}), 64'b100);
        tick();
        chk("timeout_err_pulse", 64'(err_o), 64'd0);

        // Flush during DIV at EXEC cycle 10 together with ex_valid_i
        x0 = 34'h1_2345_6789;
        x1 = 34'h2_FEDC_BA98;
        instr_valid_i = 1'b1; op_class_i = 2'd2; rd_addr_i = 5'd7;
        tick();
        instr_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imd_val_we_i = (i == 0) ? 2'b01 : ((i == 1) ? 2'b10 : 2'b00);
            imd_val_d_i[0] = x0;
            imd_val_d_i[1] = x1;
            tick();
        end
        chk("flush_pre_div_en", 64'(div_en_o), 64'd1);
        flush_i = 1'b1; ex_valid_i = 1'b1; result_ex_i = 32'hBAAD_BAAD;
        imd_val_we_i = 2'b11; imd_val_d_i = '0;
        #1 chk("flush_ready_low", 64'(instr_ready_o), 64'd0);
        tick();
        flush_i = 1'b0; ex_valid_i = 1'b0; imd_val_we_i = 2'b00;
        chk("flush_idle", 64'({busy_o, wb_valid_o, div_en_o, div_sel_o, err_o}), 64'd0);
        chk("flush_imd0", 64'(imd_val_q_o[0]), 64'(x0));
        chk("flush_imd1", 64'(imd_val_q_o[1]), 64'(x1));
        tick();
        chk("flush_no_late_wb", 64'({wb_valid_o, err_o}), 64'd0);

        // Reset in the middle of a MULT
        instr_valid_i = 1'b1; op_class_i = 2'd1; rd_addr_i = 5'd8;
        tick();
        instr_valid_i = 1'b0;
        imd_val_we_i = 2'b11; imd_val_d_i[0] = 34'h3_0000_0001; imd_val_d_i[1] = 34'h0_0000_0002;
        tick();
        imd_val_we_i = 2'b00;
        chk("mult_running", 64'({mult_en_o, busy_o}), 64'b11);
        rst_i = 1'b1;
        tick();
        chk("rst_mid_ctrl", 64'({alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o,
                                 div_sel_o, multdiv_ready_id_o, wb_valid_o, err_o, busy_o}), 64'd0);
        chk("rst_mid_ready", 64'(instr_ready_o), 64'd1);
        chk("rst_mid_imd", 64'({imd_val_q_o[1], imd_val_q_o[0]}), 64'd0);
        rst_i = 1'b0;
        tick();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
